// File: rtl/vs_uart_pkg.sv
// vs_uart_pkg: shared receiver state encoding, parity mode codes and sample voting.
package vs_uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2,
        S_WEND
    } rx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/vs_uart_rx_hold.sv
// vs_uart_rx_hold: one-entry output register with valid/ready handshake and sticky overrun.
module vs_uart_rx_hold #(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ld,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_perr,
    input  logic              ld_ferr,
    input  logic              ready,
    output logic [DATA_W-1:0] data,
    output logic              perr,
    output logic              ferr,
    output logic              valid,
    output logic              ovr
);

    logic blocked;

    // A full register that is not being drained this cycle cannot take new data.
    assign blocked = valid & ~ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data  <= '0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
            valid <= 1'b0;
            ovr   <= 1'b0;
        end else begin
            if (ld && !blocked) begin
                data <= ld_data;
                perr <= ld_perr;
                ferr <= ld_ferr;
            end
            valid <= ld | blocked;
            ovr   <= (ld & blocked) | (ovr & ~(valid & ready));
        end
    end

endmodule

// File: rtl/vs_uart_rx_core.sv
// vs_uart_rx_core: oversampled UART receiver with majority voting and a handshaked holding register.
// Define VS_UART_RX_BREAK_DET_EN to add the RX_BREAK output and suppress delivery of break frames.
module vs_uart_rx_core
    import vs_uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OVS    = 16,
    parameter int CNT_W  = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RXD,
    input  logic              OVS_CE,
    input  logic [1:0]        PAR_MODE,
    input  logic              STOP2,
    output logic [DATA_W-1:0] RX_DATA,
    output logic              RX_PERR,
    output logic              RX_FERR,
    output logic              RX_VALID,
    input  logic              RX_READY,
    output logic              RX_OVR,
    output logic              RX_BUSY
`ifdef VS_UART_RX_BREAK_DET_EN
    ,
    output logic              RX_BREAK
`endif
);

    localparam int BCNT_W = 4;
    localparam logic [CNT_W-1:0]  C_S0   = CNT_W'(OVS / 2 - 2);
    localparam logic [CNT_W-1:0]  C_S1   = CNT_W'(OVS / 2 - 1);
    localparam logic [CNT_W-1:0]  C_MID  = CNT_W'(OVS / 2);
    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(OVS - 1);
    localparam logic [BCNT_W-1:0] B_LAST = BCNT_W'(DATA_W - 1);

    rx_state_t         state;
    logic [CNT_W-1:0]  ocnt;
    logic [BCNT_W-1:0] bcnt;
    logic              s0, s1;
    logic [DATA_W-1:0] shreg;
    logic              perr_r, ferr_r, done;
    logic [1:0]        pm;
    logic              st2;
    logic              bitv, par_en, mid, last;
`ifdef VS_UART_RX_BREAK_DET_EN
    logic              par_bit, brk;
    assign RX_BREAK = brk;
`endif

    assign bitv    = maj3(s0, s1, RXD);
    assign par_en  = (pm == PAR_EVEN) || (pm == PAR_ODD);
    assign mid     = ocnt == C_MID;
    assign last    = ocnt == C_LAST;
    assign RX_BUSY = state != S_IDLE;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= S_IDLE;
            ocnt   <= '0;
            bcnt   <= '0;
            s0     <= 1'b0;
            s1     <= 1'b0;
            shreg  <= '0;
            perr_r <= 1'b0;
            ferr_r <= 1'b0;
            done   <= 1'b0;
            pm     <= PAR_NONE;
            st2    <= 1'b0;
`ifdef VS_UART_RX_BREAK_DET_EN
            par_bit <= 1'b0;
            brk     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef VS_UART_RX_BREAK_DET_EN
            brk <= 1'b0;
`endif
            if (state == S_WEND) begin
                if (RXD) state <= S_IDLE;
            end else if (OVS_CE) begin
                ocnt <= last ? '0 : ocnt + 1'b1;
                if (ocnt == C_S0) s0 <= RXD;
                if (ocnt == C_S1) s1 <= RXD;
                case (state)
                    S_IDLE: begin
                        ocnt <= '0;
                        if (!RXD) begin
                            state  <= S_START;
                            pm     <= PAR_MODE;
                            st2    <= STOP2;
                            bcnt   <= '0;
                            perr_r <= 1'b0;
                            ferr_r <= 1'b0;
                        end
                    end
                    S_START: begin
                        if (mid && bitv) begin
                            state <= S_IDLE;
                            ocnt  <= '0;
                        end else if (last) state <= S_DATA;
                    end
                    S_DATA: begin
                        if (mid) shreg <= {bitv, shreg[DATA_W-1:1]};
                        if (last) begin
                            bcnt <= (bcnt == B_LAST) ? '0 : bcnt + 1'b1;
                            if (bcnt == B_LAST) state <= par_en ? S_PARITY : S_STOP1;
                        end
                    end
                    S_PARITY: begin
                        if (mid) begin
                            perr_r <= bitv ^ (^shreg) ^ (pm == PAR_ODD);
`ifdef VS_UART_RX_BREAK_DET_EN
                            par_bit <= bitv;
`endif
                        end
                        if (last) state <= S_STOP1;
                    end
                    S_STOP1: begin
`ifdef VS_UART_RX_BREAK_DET_EN
                        if (mid && !bitv && shreg == '0 && !(par_en && par_bit)) begin
                            brk   <= 1'b1;
                            state <= S_WEND;
                            ocnt  <= '0;
                        end else
`endif
                        if (mid && st2) ferr_r <= !bitv;
                        else if (mid) begin
                            ferr_r <= !bitv;
                            done   <= 1'b1;
                            state  <= bitv ? S_IDLE : S_WEND;
                            ocnt   <= '0;
                        end else if (last && st2) state <= S_STOP2;
                    end
                    S_STOP2: begin
                        if (mid) begin
                            ferr_r <= ferr_r | !bitv;
                            done   <= 1'b1;
                            state  <= bitv ? S_IDLE : S_WEND;
                            ocnt   <= '0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    vs_uart_rx_hold #(.DATA_W(DATA_W)) u_hold (
        .CLK     (CLK),
        .RST     (RST),
        .ld      (done),
        .ld_data (shreg),
        .ld_perr (perr_r),
        .ld_ferr (ferr_r),
        .ready   (RX_READY),
        .data    (RX_DATA),
        .perr    (RX_PERR),
        .ferr    (RX_FERR),
        .valid   (RX_VALID),
        .ovr     (RX_OVR)
    );

endmodule

// File: tb/tb_vs_uart_rx_core.sv
// tb_vs_uart_rx_core: randomized and directed frames checked against a line-level frame model.
module tb_vs_uart_rx_core;

    localparam int OVS = 16;

    logic       CLK = 1'b0, RST = 1'b1, RXD = 1'b1, OVS_CE = 1'b0, STOP2 = 1'b0, RX_READY = 1'b1;
    logic [1:0] PAR_MODE = 2'b00;
    logic [7:0] RX_DATA;
    logic       RX_PERR, RX_FERR, RX_VALID, RX_OVR, RX_BUSY;
`ifdef VS_UART_RX_BREAK_DET_EN
    logic       RX_BREAK;
`endif

    int n_chk = 0, n_fail = 0;
    int tdiv = 0;
    int vcnt = 0, bcnt = 0, wr = 0, rd = 0;
    logic [9:0] rxm [0:255];

    vs_uart_rx_core #(.DATA_W(8), .OVS(OVS), .CNT_W(5)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .RXD      (RXD),
        .OVS_CE   (OVS_CE),
        .PAR_MODE (PAR_MODE),
        .STOP2    (STOP2),
        .RX_DATA  (RX_DATA),
        .RX_PERR  (RX_PERR),
        .RX_FERR  (RX_FERR),
        .RX_VALID (RX_VALID),
        .RX_READY (RX_READY),
        .RX_OVR   (RX_OVR),
        .RX_BUSY  (RX_BUSY)
`ifdef VS_UART_RX_BREAK_DET_EN
        ,
        .RX_BREAK (RX_BREAK)
`endif
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        tdiv   <= (tdiv == 2) ? 0 : tdiv + 1;
        OVS_CE <= (tdiv == 2);
    end

    // Every accepted handshake is logged; tests consume entries from rd.
    always @(negedge CLK) begin
        if (!RST) begin
            if (RX_VALID) vcnt++;
`ifdef VS_UART_RX_BREAK_DET_EN
            if (RX_BREAK) bcnt++;
`endif
            if (RX_VALID && RX_READY) begin
                rxm[wr & 255] = {RX_DATA, RX_PERR, RX_FERR};
                wr++;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_tick();
        @(posedge CLK);
        while (!OVS_CE) @(posedge CLK);
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        wait_tick();
        #1;
        for (int i = 0; i < n; i++) begin
            RXD = bits[i];
            repeat (OVS) wait_tick();
            #1;
        end
    endtask

    // Line image of a frame, and the flags a correct receiver must report for it.
    task automatic build(input logic [7:0] d, input logic [1:0] pm, input logic s2, input logic pflip,
                         input logic slow, output logic [15:0] bits, output int n,
                         output logic eperr, output logic eferr);
        logic pen, pb;
        pen  = (pm == 2'b01) || (pm == 2'b10);
        pb   = ($countones(d) % 2 == ((pm == 2'b10) ? 0 : 1)) ^ pflip;
        bits = '1;
        n    = 0;
        bits[n] = 1'b0;
        n++;
        for (int i = 0; i < 8; i++) begin
            bits[n] = d[i];
            n++;
        end
        if (pen) begin
            bits[n] = pb;
            n++;
        end
        if (s2) begin
            bits[n] = 1'b1;
            n++;
        end
        bits[n] = !slow;
        n++;
        eperr = pen && ((($countones(d) + int'(pb)) % 2) != ((pm == 2'b10) ? 1 : 0));
        eferr = slow;
    endtask

    task automatic get_frame(output int cnt, output logic [9:0] f);
        cnt = wr - rd;
        f   = (cnt > 0) ? rxm[rd & 255] : 10'bx;
        rd  = wr;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        RXD = 1'b1;
        repeat (3) @(negedge CLK);
        n_chk++;
        if ({RX_VALID, RX_DATA, RX_PERR, RX_FERR, RX_OVR, RX_BUSY} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", {RX_VALID, RX_DATA, RX_PERR, RX_FERR, RX_OVR, RX_BUSY});
        end
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        n_chk++;
        if (RX_BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", RX_BUSY); end
    endtask

    task automatic test_8n1();
        logic [15:0] b; int n, cnt, v0; logic ep, ef; logic [9:0] f;
        PAR_MODE = 2'b00; STOP2 = 1'b0;
        build(8'hA5, 2'b00, 1'b0, 1'b0, 1'b0, b, n, ep, ef);
        v0 = vcnt;
        send_bits(b, n);
        RXD = 1'b1;
        repeat (3) @(negedge CLK);
        get_frame(cnt, f);
        n_chk++; if (cnt !== 1) begin n_fail++; $display("FAIL a5_count: got %0d want 1", cnt); end
        n_chk++; if (f[9:2] !== 8'hA5) begin n_fail++; $display("FAIL a5_data: got %h want a5", f[9:2]); end
        n_chk++; if (f[1:0] !== {ep, ef}) begin n_fail++; $display("FAIL a5_flags: got %b want %b", f[1:0], {ep, ef}); end
        n_chk++; if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL a5_valid_cycles: got %0d want 1", vcnt - v0); end
    endtask

    task automatic test_parity_err();
        logic [15:0] b; int n, cnt; logic ep, ef; logic [9:0] f;
        PAR_MODE = 2'b10; STOP2 = 1'b1;
        build(8'h3C, 2'b10, 1'b1, 1'b1, 1'b0, b, n, ep, ef);
        send_bits(b, n);
        RXD = 1'b1;
        PAR_MODE = 2'b00; STOP2 = 1'b0;
        repeat (3) @(negedge CLK);
        get_frame(cnt, f);
        n_chk++; if (cnt !== 1) begin n_fail++; $display("FAIL 3c_count: got %0d want 1", cnt); end
        n_chk++; if (f[9:2] !== 8'h3C) begin n_fail++; $display("FAIL 3c_data: got %h want 3c", f[9:2]); end
        n_chk++; if (f[1:0] !== 2'b10) begin n_fail++; $display("FAIL 3c_perr_ferr: got %b want 10", f[1:0]); end
    endtask

    task automatic test_glitch();
        int cnt; logic [9:0] f;
        wait_tick();
        #1 RXD = 1'b0;
        repeat (4) wait_tick();
        #1 RXD = 1'b1;
        n_chk++; if (RX_BUSY !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_during: got %b want 1", RX_BUSY); end
        repeat (OVS) wait_tick();
        #1;
        get_frame(cnt, f);
        n_chk++; if (RX_BUSY !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_after: got %b want 0", RX_BUSY); end
        n_chk++; if (cnt !== 0 || RX_VALID !== 1'b0) begin n_fail++; $display("FAIL glitch_no_frame: got %0d/%b want 0/0", cnt, RX_VALID); end
    endtask

    task automatic test_overrun();
        logic [15:0] b; int n, cnt; logic ep, ef; logic [9:0] f;
        @(negedge CLK); #1 RX_READY = 1'b0;
        build(8'h11, 2'b00, 1'b0, 1'b0, 1'b0, b, n, ep, ef);
        send_bits(b, n);
        RXD = 1'b1;
        build(8'h22, 2'b00, 1'b0, 1'b0, 1'b0, b, n, ep, ef);
        send_bits(b, n);
        RXD = 1'b1;
        repeat (3) @(negedge CLK);
        n_chk++; if (RX_VALID !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b want 1", RX_VALID); end
        n_chk++; if (RX_DATA !== 8'h11) begin n_fail++; $display("FAIL ovr_keep_old: got %h want 11", RX_DATA); end
        n_chk++; if (RX_OVR !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b want 1", RX_OVR); end
        #1 RX_READY = 1'b1;
        @(negedge CLK);
        get_frame(cnt, f);
        n_chk++; if (RX_VALID !== 1'b0) begin n_fail++; $display("FAIL ovr_valid_clear: got %b want 0", RX_VALID); end
        n_chk++; if (RX_OVR !== 1'b0) begin n_fail++; $display("FAIL ovr_flag_clear: got %b want 0", RX_OVR); end
    endtask

    task automatic test_wend();
        logic [15:0] b; int n, cnt; logic ep, ef; logic [9:0] f;
        PAR_MODE = 2'b01; STOP2 = 1'b0;
        build(8'h55, 2'b01, 1'b0, 1'b0, 1'b1, b, n, ep, ef);
        send_bits(b, n);
        repeat (3) @(negedge CLK);
        get_frame(cnt, f);
        n_chk++; if (cnt !== 1) begin n_fail++; $display("FAIL wend_count: got %0d want 1", cnt); end
        n_chk++; if (f !== {8'h55, ep, ef}) begin n_fail++; $display("FAIL wend_frame: got %h want %h", f, {8'h55, ep, ef}); end
        repeat (2 * OVS) wait_tick();
        #1;
        n_chk++; if (RX_BUSY !== 1'b1) begin n_fail++; $display("FAIL wend_hold: got %b want 1", RX_BUSY); end
        RXD = 1'b1;
        repeat (2) @(negedge CLK);
        n_chk++; if (RX_BUSY !== 1'b0) begin n_fail++; $display("FAIL wend_release: got %b want 0", RX_BUSY); end
        build(8'h66, 2'b01, 1'b0, 1'b0, 1'b0, b, n, ep, ef);
        send_bits(b, n);
        RXD = 1'b1;
        repeat (3) @(negedge CLK);
        get_frame(cnt, f);
        n_chk++; if (cnt !== 1 || f !== {8'h66, ep, ef}) begin n_fail++; $display("FAIL wend_next: got %0d %h want 1 %h", cnt, f, {8'h66, ep, ef}); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] b; int n, cnt; logic ep, ef; logic [9:0] f;
        PAR_MODE = 2'b00; STOP2 = 1'b0;
        @(negedge CLK); #1 RX_READY = 1'b0;
        build(8'h5A, 2'b00, 1'b0, 1'b0, 1'b0, b, n, ep, ef);
        send_bits(b, n);
        RXD = 1'b1;
        repeat (3) @(negedge CLK);
        n_chk++; if (RX_VALID !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_valid: got %b want 1", RX_VALID); end
        build(8'hFF, 2'b00, 1'b0, 1'b0, 1'b0, b, n, ep, ef);
        send_bits(b, 6);
        n_chk++; if (RX_BUSY !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy: got %b want 1", RX_BUSY); end
        RST = 1'b1;
        @(negedge CLK);
        n_chk++;
        if ({RX_VALID, RX_DATA, RX_PERR, RX_FERR, RX_OVR, RX_BUSY} !== 13'h0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got %h want 0", {RX_VALID, RX_DATA, RX_PERR, RX_FERR, RX_OVR, RX_BUSY});
        end
        RXD = 1'b1;
        RST = 1'b0;
        RX_READY = 1'b1;
        get_frame(cnt, f);
        repeat (OVS * 3 * 12) @(negedge CLK);
        get_frame(cnt, f);
        n_chk++; if (cnt !== 0) begin n_fail++; $display("FAIL rstmid_no_frame: got %0d want 0", cnt); end
        build(8'h81, 2'b00, 1'b0, 1'b0, 1'b0, b, n, ep, ef);
        send_bits(b, n);
        RXD = 1'b1;
        repeat (3) @(negedge CLK);
        get_frame(cnt, f);
        n_chk++; if (cnt !== 1 || f !== {8'h81, 2'b00}) begin n_fail++; $display("FAIL rstmid_next: got %0d %h want 1 %h", cnt, f, {8'h81, 2'b00}); end
    endtask

    task automatic test_break_frame();
        logic [15:0] b; int n, cnt, b0; logic ep, ef; logic [9:0] f;
        PAR_MODE = 2'b00; STOP2 = 1'b0;
        build(8'h00, 2'b00, 1'b0, 1'b0, 1'b1, b, n, ep, ef);
        b0 = bcnt;
        send_bits(b, n);
        RXD = 1'b1;
        repeat (3) @(negedge CLK);
        get_frame(cnt, f);
`ifdef VS_UART_RX_BREAK_DET_EN
        n_chk++; if (cnt !== 0) begin n_fail++; $display("FAIL brk_no_frame: got %0d want 0", cnt); end
        n_chk++; if (bcnt - b0 !== 1) begin n_fail++; $display("FAIL brk_pulse: got %0d want 1", bcnt - b0); end
`else
        n_chk++; if (cnt !== 1 || f !== 10'b0000000001) begin n_fail++; $display("FAIL brk_as_ferr: got %0d %h want 1 001 (b0=%0d)", cnt, f, b0); end
`endif
    endtask

    task automatic test_random();
        logic [15:0] b; int n, cnt; logic ep, ef; logic [9:0] f;
        logic [7:0] d; logic [1:0] pm; logic s2, pf, sl;
        for (int k = 0; k < 14; k++) begin
            d  = 8'($urandom_range(1, 255));
            pm = 2'($urandom_range(0, 3));
            s2 = 1'($urandom_range(0, 1));
            pf = 1'($urandom_range(0, 1));
            sl = ($urandom_range(0, 3) == 0);
            PAR_MODE = pm; STOP2 = s2;
            build(d, pm, s2, pf, sl, b, n, ep, ef);
            send_bits(b, n);
            RXD = 1'b1;
            PAR_MODE = 2'($urandom_range(0, 3));
            STOP2 = 1'($urandom_range(0, 1));
            repeat (3) @(negedge CLK);
            get_frame(cnt, f);
            n_chk++;
            if (cnt !== 1 || f !== {d, ep, ef}) begin
                n_fail++;
                $display("FAIL rand_%0d: got %0d %h want 1 %h (pm=%b s2=%b)", k, cnt, f, {d, ep, ef}, pm, s2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity_err();
        test_glitch();
        test_overrun();
        test_wend();
        test_reset_mid();
        test_break_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
